// File: rtl/recon_mul.sv
// recon_mul: sequential multiply-accumulate, Product = Multiplicand * Multiplier + Addend.
// Unsigned 16x16 shift-and-add, one multiplier bit per cycle (LSB first), with the
// accumulator preloaded with the addend. The worst case is 0xFFFF0000, so the result
// always fits in 32 bits.
//
// Ports:
//   Clock        in   1   rising-edge clock
//   Reset        in   1   synchronous active-high reset
//   Start        in   1   request, honoured only in IDLE
//   Multiplicand in  16   operand A
//   Multiplier   in  16   operand B
//   Addend       in  16   operand C
//   Product      out 32   registered A*B+C, held until the next completion
//   Busy         out  1   high while in RUN
//   Done         out  1   one-cycle pulse while in DONE
//   Overflow     out  1   only with RECON_MUL_OVERFLOW_EN: OR of Product[31:16]
//
// Optional feature macro: RECON_MUL_OVERFLOW_EN
//
// state | meaning
// IDLE  | waiting for Start; operands captured on acceptance
// RUN   | 16 cycles, one multiplier bit processed per cycle
// DONE  | one cycle, Product valid and Done high; always returns to IDLE

module recon_mul (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Multiplicand,
    input  logic [15:0] Multiplier,
    input  logic [15:0] Addend,
    output logic [31:0] Product,
    output logic        Busy,
    output logic        Done
`ifdef RECON_MUL_OVERFLOW_EN
    ,
    output logic        Overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [31:0] acc;
    logic [3:0]  cnt;
    logic [31:0] a_shifted;
    logic [31:0] acc_next;
    logic        last_bit;

    assign a_shifted = {16'd0, a_reg} << cnt;
    assign acc_next  = b_reg[cnt] ? (acc + a_shifted) : acc;
    assign last_bit  = (cnt == 4'd15);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: Product is only ever written on the last RUN cycle, so an
    // operation aborted by Reset leaves no trace beyond the cleared registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_reg   <= 16'd0;
            b_reg   <= 16'd0;
            acc     <= 32'd0;
            cnt     <= 4'd0;
            Product <= 32'd0;
`ifdef RECON_MUL_OVERFLOW_EN
            Overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg <= Multiplicand;
                        b_reg <= Multiplier;
                        acc   <= {16'd0, Addend};
                        cnt   <= 4'd0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 4'd1;
                    if (last_bit) begin
                        Product <= acc_next;
`ifdef RECON_MUL_OVERFLOW_EN
                        Overflow <= |acc_next[31:16];
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
